// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcodes, state
// encoding, datapath mux selects and the packed control-word layout.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNC_JR  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        MEM_WB  = 4'd4,
        MEM_WR  = 4'd5,
        R_EX    = 4'd6,
        R_WB    = 4'd7,
        BRANCH  = 4'd8,
        I_EX    = 4'd9,
        I_WB    = 4'd10,
        JUMP    = 4'd11,
        JAL     = 4'd12,
        JR      = 4'd13
    } state_t;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG_A  = 2'b11;

    localparam logic [1:0] ALU_B_REG    = 2'b00;
    localparam logic [1:0] ALU_B_FOUR   = 2'b01;
    localparam logic [1:0] ALU_B_IMM    = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [1:0] ALU_OP_FUNC = 2'b10;
    localparam logic [1:0] ALU_OP_SLT  = 2'b11;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_perf_counters.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
module mc_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= {CNT_W{1'b0}};
            instr_cnt <= {CNT_W{1'b0}};
        end else begin
            cycle_cnt <= cycle_cnt + ONE;
            if (instr_done) begin
                instr_cnt <= instr_cnt + ONE;
            end else begin
                instr_cnt <= instr_cnt;
            end
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM. Define MC_PERF_CNT_EN to add the
// cycle_cnt/instr_cnt performance counter outputs.
module multicycle_control
    import mc_pkg::*;
`ifdef MC_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_t state_r;
    state_t next_state_s;
    ctrl_t  dec_s;
    ctrl_t  ctrl_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and Moore output decode; reset forces every output low
    always_comb begin
        next_state_s = state_r;
        dec_s        = '0;
        case (state_r)
            FETCH: begin
                dec_s.mem_read  = 1'b1;
                dec_s.alu_src_b = ALU_B_FOUR;
                if (mem_ready) begin
                    dec_s.ir_write = 1'b1;
                    dec_s.pc_en    = 1'b1;
                    next_state_s   = DECODE;
                end else begin
                    next_state_s   = FETCH;
                end
            end
            DECODE: begin
                dec_s.alu_src_b = ALU_B_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW:     next_state_s = MEM_ADR;
                    OP_RTYPE: begin
                        if (func == FUNC_JR) begin
                            next_state_s = JR;
                        end else begin
                            next_state_s = R_EX;
                        end
                    end
                    OP_BEQ, OP_BNE:   next_state_s = BRANCH;
                    OP_ADDI, OP_SLTI: next_state_s = I_EX;
                    OP_J:             next_state_s = JUMP;
                    OP_JAL:           next_state_s = JAL;
                    default: begin
                        dec_s.illegal_op = 1'b1;
                        next_state_s     = FETCH;
                    end
                endcase
            end
            MEM_ADR: begin
                dec_s.alu_src_a = 1'b1;
                dec_s.alu_src_b = ALU_B_IMM;
                if (opcode == OP_SW) begin
                    next_state_s = MEM_WR;
                end else begin
                    next_state_s = MEM_RD;
                end
            end
            MEM_RD: begin
                dec_s.mem_read = 1'b1;
                dec_s.i_or_d   = 1'b1;
                if (mem_ready) begin
                    next_state_s = MEM_WB;
                end else begin
                    next_state_s = MEM_RD;
                end
            end
            MEM_WB: begin
                dec_s.reg_write  = 1'b1;
                dec_s.reg_dst    = REG_DST_RT;
                dec_s.mem_to_reg = M2R_MDR;
                next_state_s     = FETCH;
            end
            MEM_WR: begin
                dec_s.mem_write = 1'b1;
                dec_s.i_or_d    = 1'b1;
                if (mem_ready) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = MEM_WR;
                end
            end
            R_EX: begin
                dec_s.alu_src_a = 1'b1;
                dec_s.alu_src_b = ALU_B_REG;
                dec_s.alu_op    = ALU_OP_FUNC;
                next_state_s    = R_WB;
            end
            R_WB: begin
                dec_s.reg_write  = 1'b1;
                dec_s.reg_dst    = REG_DST_RD;
                dec_s.mem_to_reg = M2R_ALUOUT;
                next_state_s     = FETCH;
            end
            BRANCH: begin
                dec_s.alu_src_a = 1'b1;
                dec_s.alu_src_b = ALU_B_REG;
                dec_s.alu_op    = ALU_OP_SUB;
                dec_s.pc_src    = PC_SRC_ALUOUT;
                if (opcode == OP_BEQ) begin
                    dec_s.pc_en = zero;
                end else if (opcode == OP_BNE) begin
                    dec_s.pc_en = ~zero;
                end else begin
                    dec_s.pc_en = 1'b0;
                end
                next_state_s = FETCH;
            end
            I_EX: begin
                dec_s.alu_src_a = 1'b1;
                dec_s.alu_src_b = ALU_B_IMM;
                if (opcode == OP_SLTI) begin
                    dec_s.alu_op = ALU_OP_SLT;
                end else begin
                    dec_s.alu_op = ALU_OP_ADD;
                end
                next_state_s = I_WB;
            end
            I_WB: begin
                dec_s.reg_write  = 1'b1;
                dec_s.reg_dst    = REG_DST_RT;
                dec_s.mem_to_reg = M2R_ALUOUT;
                next_state_s     = FETCH;
            end
            JUMP: begin
                dec_s.pc_src = PC_SRC_JUMP;
                dec_s.pc_en  = 1'b1;
                next_state_s = FETCH;
            end
            JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                dec_s.pc_src     = PC_SRC_JUMP;
                dec_s.pc_en      = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.reg_dst    = REG_DST_RA;
                dec_s.mem_to_reg = M2R_PC;
                next_state_s     = FETCH;
            end
            JR: begin
                dec_s.pc_src = PC_SRC_REG_A;
                dec_s.pc_en  = 1'b1;
                next_state_s = FETCH;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
        if (rst) begin
            ctrl_s = '0;
        end else begin
            ctrl_s = dec_s;
        end
    end

    assign mem_read   = ctrl_s.mem_read;
    assign mem_write  = ctrl_s.mem_write;
    assign i_or_d     = ctrl_s.i_or_d;
    assign ir_write   = ctrl_s.ir_write;
    assign pc_en      = ctrl_s.pc_en;
    assign pc_src     = ctrl_s.pc_src;
    assign alu_src_a  = ctrl_s.alu_src_a;
    assign alu_src_b  = ctrl_s.alu_src_b;
    assign alu_op     = ctrl_s.alu_op;
    assign reg_dst    = ctrl_s.reg_dst;
    assign mem_to_reg = ctrl_s.mem_to_reg;
    assign reg_write  = ctrl_s.reg_write;
    assign illegal_op = ctrl_s.illegal_op;

`ifdef MC_PERF_CNT_EN
    logic instr_done_s;
    assign instr_done_s = (state_r != FETCH) && (next_state_s == FETCH);

    mc_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk        (clk),
        .rst        (rst),
        .instr_done (instr_done_s),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: one vector per clock cycle,
// followed by a hand-written reset-during-MEM_RD sequence.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_en, alu_src_a, reg_write, illegal_op;
    logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
    logic [31:0] exp_cyc;
    int          exp_instr = 0;
`endif

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_op(illegal_op)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

`ifdef MC_PERF_CNT_EN
    always @(posedge clk or posedge rst) begin
        if (rst) exp_cyc <= 32'd0;
        else     exp_cyc <= exp_cyc + 32'd1;
    end
`endif

    logic [17:0] ctrl;
    assign ctrl = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op};

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [17:0] exp;
        logic        done;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic logic [17:0] o(input logic mr, input logic mw, input logic iod,
                                      input logic irw, input logic pce, input logic [1:0] pcs,
                                      input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                      input logic [1:0] rd, input logic [1:0] m2r,
                                      input logic rw, input logic ill);
        return {mr, mw, iod, irw, pce, pcs, asa, asb, aop, rd, m2r, rw, ill};
    endfunction

    task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [17:0] e, input logic d);
        vec_t v;
        v.name = nm; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e; v.done = d;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare mid-cycle, advance to the next falling edge
    task automatic step(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [17:0] e);
        opcode = op; func = fn; zero = z; mem_ready = rdy;
        #1;
        check(nm, ctrl, e);
        @(negedge clk);
    endtask

    logic [17:0] F_R, F_W, DEC, DEC_ILL, MADR, MRD, MWB, MWR, REX, RWB;
    logic [17:0] BR_T, BR_N, IEX_ADD, IEX_SLT, IWB, JMP, JL, JRS, ZERO;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] SLTI = 6'b001010, J = 6'b000010, JALO = 6'b000011;
    localparam logic [5:0] ILL = 6'b111111, F_ADD = 6'b100000, F_JR = 6'b001000;

    initial begin
        F_R     = o(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        F_W     = o(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        DEC     = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        DEC_ILL = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        MADR    = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        MRD     = o(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        MWB     = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
        MWR     = o(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        REX     = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        RWB     = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0);
        BR_T    = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        BR_N    = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        IEX_ADD = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        IEX_SLT = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        IWB     = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        JMP     = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        JL      = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0);
        JRS     = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        ZERO    = 18'd0;

        // lw with one MEM_RD wait cycle
        add("lw_fetch",   LW, 6'd0, 1'b0, 1'b0, F_W,  1'b0);
        add("lw_fetch",   LW, 6'd0, 1'b0, 1'b1, F_R,  1'b0);
        add("lw_decode",  LW, 6'd0, 1'b0, 1'b1, DEC,  1'b0);
        add("lw_memadr",  LW, 6'd0, 1'b0, 1'b1, MADR, 1'b0);
        add("lw_memrd_w", LW, 6'd0, 1'b0, 1'b0, MRD,  1'b0);
        add("lw_memrd",   LW, 6'd0, 1'b0, 1'b1, MRD,  1'b0);
        add("lw_memwb",   LW, 6'd0, 1'b0, 1'b1, MWB,  1'b1);
        // lw zero-wait: 5 cycles
        add("lw0_fetch",  LW, 6'd0, 1'b0, 1'b1, F_R,  1'b0);
        add("lw0_decode", LW, 6'd0, 1'b0, 1'b1, DEC,  1'b0);
        add("lw0_memadr", LW, 6'd0, 1'b0, 1'b1, MADR, 1'b0);
        add("lw0_memrd",  LW, 6'd0, 1'b0, 1'b1, MRD,  1'b0);
        add("lw0_memwb",  LW, 6'd0, 1'b0, 1'b1, MWB,  1'b1);
        // sw with three wait cycles
        add("sw_fetch",   SW, 6'd0, 1'b0, 1'b1, F_R,  1'b0);
        add("sw_decode",  SW, 6'd0, 1'b0, 1'b0, DEC,  1'b0);
        add("sw_memadr",  SW, 6'd0, 1'b0, 1'b0, MADR, 1'b0);
        add("sw_memwr_w1",SW, 6'd0, 1'b0, 1'b0, MWR,  1'b0);
        add("sw_memwr_w2",SW, 6'd0, 1'b0, 1'b0, MWR,  1'b0);
        add("sw_memwr_w3",SW, 6'd0, 1'b0, 1'b0, MWR,  1'b0);
        add("sw_memwr",   SW, 6'd0, 1'b0, 1'b1, MWR,  1'b1);
        // R-type add
        add("r_fetch",    RT, F_ADD, 1'b0, 1'b1, F_R, 1'b0);
        add("r_decode",   RT, F_ADD, 1'b0, 1'b1, DEC, 1'b0);
        add("r_ex",       RT, F_ADD, 1'b1, 1'b1, REX, 1'b0);
        add("r_wb",       RT, F_ADD, 1'b0, 1'b1, RWB, 1'b1);
        // Branches
        add("beq1_fetch", BEQ, 6'd0, 1'b0, 1'b1, F_R,  1'b0);
        add("beq1_decode",BEQ, 6'd0, 1'b0, 1'b1, DEC,  1'b0);
        add("beq1_branch",BEQ, 6'd0, 1'b1, 1'b1, BR_T, 1'b1);
        add("beq0_fetch", BEQ, 6'd0, 1'b0, 1'b1, F_R,  1'b0);
        add("beq0_decode",BEQ, 6'd0, 1'b0, 1'b1, DEC,  1'b0);
        add("beq0_branch",BEQ, 6'd0, 1'b0, 1'b1, BR_N, 1'b1);
        add("bne0_fetch", BNE, 6'd0, 1'b0, 1'b1, F_R,  1'b0);
        add("bne0_decode",BNE, 6'd0, 1'b0, 1'b1, DEC,  1'b0);
        add("bne0_branch",BNE, 6'd0, 1'b0, 1'b1, BR_T, 1'b1);
        add("bne1_fetch", BNE, 6'd0, 1'b0, 1'b1, F_R,  1'b0);
        add("bne1_decode",BNE, 6'd0, 1'b0, 1'b1, DEC,  1'b0);
        add("bne1_branch",BNE, 6'd0, 1'b1, 1'b1, BR_N, 1'b1);
        // Immediates
        add("addi_fetch", ADDI, 6'd0, 1'b0, 1'b1, F_R,     1'b0);
        add("addi_decode",ADDI, 6'd0, 1'b0, 1'b1, DEC,     1'b0);
        add("addi_ex",    ADDI, 6'd0, 1'b0, 1'b1, IEX_ADD, 1'b0);
        add("addi_wb",    ADDI, 6'd0, 1'b0, 1'b1, IWB,     1'b1);
        add("slti_fetch", SLTI, 6'd0, 1'b0, 1'b1, F_R,     1'b0);
        add("slti_decode",SLTI, 6'd0, 1'b0, 1'b1, DEC,     1'b0);
        add("slti_ex",    SLTI, 6'd0, 1'b0, 1'b1, IEX_SLT, 1'b0);
        add("slti_wb",    SLTI, 6'd0, 1'b0, 1'b1, IWB,     1'b1);
        // Jumps
        add("j_fetch",    J,    6'd0, 1'b0, 1'b1, F_R, 1'b0);
        add("j_decode",   J,    6'd0, 1'b0, 1'b1, DEC, 1'b0);
        add("j_jump",     J,    6'd0, 1'b0, 1'b1, JMP, 1'b1);
        add("jal_fetch",  JALO, 6'd0, 1'b0, 1'b1, F_R, 1'b0);
        add("jal_decode", JALO, 6'd0, 1'b0, 1'b1, DEC, 1'b0);
        add("jal_jal",    JALO, 6'd0, 1'b0, 1'b1, JL,  1'b1);
        add("jr_fetch",   RT,   F_JR, 1'b0, 1'b1, F_R, 1'b0);
        add("jr_decode",  RT,   F_JR, 1'b0, 1'b1, DEC, 1'b0);
        add("jr_jr",      RT,   F_JR, 1'b0, 1'b1, JRS, 1'b1);
        // Illegal opcode: single-cycle pulse, then back in FETCH
        add("ill_fetch",  ILL,  6'd0, 1'b0, 1'b1, F_R,     1'b0);
        add("ill_decode", ILL,  6'd0, 1'b0, 1'b1, DEC_ILL, 1'b1);
        add("ill_refetch",ILL,  6'd0, 1'b0, 1'b0, F_W,     1'b0);
        add("ill_refetch",J,    6'd0, 1'b0, 1'b1, F_R,     1'b0);
        add("post_decode",J,    6'd0, 1'b0, 1'b1, DEC,     1'b0);
        add("post_jump",  J,    6'd0, 1'b0, 1'b1, JMP,     1'b1);

        rst = 1'b1; opcode = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        check("reset_state", ctrl, ZERO);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy, vecs[i].exp);
`ifdef MC_PERF_CNT_EN
            if (vecs[i].done) exp_instr++;
`endif
        end

`ifdef MC_PERF_CNT_EN
        checks++;
        if (cycle_cnt !== exp_cyc) begin
            fails++;
            $display("FAIL cycle_cnt: got %0d expected %0d", cycle_cnt, exp_cyc);
        end
        checks++;
        if (instr_cnt !== 32'(exp_instr)) begin
            fails++;
            $display("FAIL instr_cnt: got %0d expected %0d", instr_cnt, exp_instr);
        end
`endif

        // Reset asserted while holding in MEM_RD
        step("rst_fetch",  LW, 6'd0, 1'b0, 1'b1, F_R);
        step("rst_decode", LW, 6'd0, 1'b0, 1'b1, DEC);
        step("rst_memadr", LW, 6'd0, 1'b0, 1'b1, MADR);
        mem_ready = 1'b0;
        #1;
        check("rst_memrd", ctrl, MRD);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", ctrl, ZERO);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_held_outputs", ctrl, ZERO);
        @(negedge clk);
        rst = 1'b0;
        step("rst_release_fetch", LW, 6'd0, 1'b0, 1'b0, F_W);
        step("rst_release_fetch", LW, 6'd0, 1'b0, 1'b1, F_R);
        step("rst_release_decode", LW, 6'd0, 1'b0, 1'b1, DEC);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath, sharing one memory port and one ALU across instruction phases.
- Sequences fetch, decode, execute, memory and writeback for each instruction and drives every datapath mux and enable.
- Supports memory wait states via a ready handshake.
- Sits beside the existing ALU-control block, which consumes alu_op and func.

Parameters:
- CNT_W, 32, width of the performance counters (used only with MC_PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- opcode  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational, this cycle
- mem_ready  in  1  memory has completed the current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  IR load enable
- pc_en  out  1  PC load enable
- pc_src  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target, 11=register A (jr)
- alu_src_a  out  1  ALU A operand select: 0=PC, 1=A
- alu_src_b  out  2  ALU B operand select: 00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2
- alu_op  out  2  00=add, 01=sub, 10=by func, 11=slt
- reg_dst  out  2  write register select: 00=rt, 01=rd, 10=31
- mem_to_reg  out  2  write data select: 00=ALUOut, 01=MDR, 10=PC
- reg_write  out  1  register file write enable
- illegal_op  out  1  one-cycle pulse on an undecodable opcode

Behaviour:
- Clocking: clk; reset is asynchronous, active-high.
- Reset: state <= FETCH. While rst is high, every output is 0.
- Output style: Moore decode of state. Two outputs are gated combinationally:
  - pc_en in BEQ/BNE depends on zero.
  - Memory-state side effects depend on mem_ready.
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - bne 000101
  - addi 001000
  - slti 001010
  - j 000010
  - jal 000011
- jr is R-type with func 001000.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_en are asserted only when mem_ready=1; the FSM then goes to DECODE.
  - Otherwise the FSM stays in FETCH and the PC/IR are untouched.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target into ALUOut).
  - Next state by opcode:
    - lw/sw -> MEM_ADR
    - R-type with func 001000 -> JR
    - other R-type -> R_EX
    - beq/bne -> BRANCH
    - addi/slti -> I_EX
    - j -> JUMP
    - jal -> JAL
    - anything else -> FETCH, with illegal_op=1 for that cycle
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01. Next: FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then -> FETCH. mem_write stays asserted throughout the hold.
- R_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Next: R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00. Next: FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_en = zero for beq, ~zero for bne.
  - Next: FETCH.
- I_EX: alu_src_a=1, alu_src_b=10; alu_op=00 for addi, 11 for slti. Next: I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00. Next: FETCH.
- JUMP: pc_src=10, pc_en=1. Next: FETCH.
- JAL: pc_src=10, pc_en=1, reg_write=1, reg_dst=10, mem_to_reg=10. The PC written is the already-incremented PC+4. Next: FETCH.
- JR: pc_src=11, pc_en=1. Next: FETCH.
- Opcode/func are sampled from the IR. The IR is stable from DECODE onward, so no latching is needed here.
- Latency, in cycles with zero-wait memory:
  - lw 5
  - sw, R-type, addi, slti: 4
  - beq, bne, j, jal, jr: 3
  - Each wait cycle adds 1.
- rst asserted mid-instruction: immediate return to FETCH; no partial write completes after the reset edge.
- mem_ready asserted outside FETCH/MEM_RD/MEM_WR: ignored.
- Unused outputs in any state are 0.

Optional Feature:
- Macro: MC_PERF_CNT_EN
- Defined:
  - Adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0], both 0 on reset.
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on each transition into FETCH from a terminal state (illegal ops included).
  - Both wrap modulo 2^CNT_W.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mc_pkg holds:
  - opcode and func constants
  - the state enum (FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB, BRANCH, I_EX, I_WB, JUMP, JAL, JR)
  - mux-select encodings for pc_src, alu_src_b, alu_op, reg_dst and mem_to_reg
- Sub-module mc_perf_counters holds the counters and is instantiated only under MC_PERF_CNT_EN.
- The FSM stays flat.

Test Plan:
- lw (opcode 100011), mem_ready held 1 -> state path FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB; reg_write=1 with mem_to_reg=01 in cycle 5; pc_en only in cycle 1.
- sw with mem_ready=0 for 3 cycles in MEM_WR -> mem_write=1 for 4 consecutive cycles, then FETCH; reg_write never asserted.
- Branch conditions:
  - beq with zero=1 -> pc_en=1, pc_src=01 in BRANCH.
  - beq with zero=0 -> pc_en=0.
  - bne with zero=0 -> pc_en=1.
- jal (000011) -> cycle 3: pc_en=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- Illegal opcode 111111 in DECODE -> illegal_op=1 for exactly 1 cycle, next state FETCH, no write enables asserted.
- rst pulsed during MEM_RD -> all outputs 0 immediately; after release, the first cycle is FETCH with mem_read=1 and i_or_d=0.
